vec_mat_mover: RTL and testbench
================================

Name: vec_mat_mover

Overview:
- Command-driven sequencer that owns read port A and the write port of vec_ram while a bulk matrix/vector transfer runs.
- Supports four operations:
  - zero a matrix
  - broadcast a vector into every row of a matrix
  - copy a matrix
  - extract one matrix row into a vector register
- Sits beside the execute stage. The core muxes vec_ram port A and the write port to this block while o_busy is high, and stalls vector issue.

Parameters:
- VEC_SIZE, 16, bit width of one lane; a row/vector is 16 lanes of VEC_SIZE bits.
- VEC_INDEX_WIDTH, 5, width of vector/matrix register index (32 vectors, 32 matrices).

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only in IDLE; command accepted on posedge when valid&ready.
- i_cmd_op  in  2  operation code: 0 ZERO, 1 FILL, 2 COPY, 3 EXTRACT.
- i_cmd_dst  in  VEC_INDEX_WIDTH  destination index (matrix for ZERO/FILL/COPY, vector for EXTRACT).
- i_cmd_src  in  VEC_INDEX_WIDTH  source index (vector for FILL, matrix for COPY/EXTRACT; ignored for ZERO).
- i_cmd_row  in  4  source row for EXTRACT; ignored otherwise.
- o_busy  out  1  high in RUN and DONE.
- o_done  out  1  one-cycle completion pulse.
- o_read_index_a  out  VEC_INDEX_WIDTH  vec_ram read index A.
- o_read_row_a  out  4  vec_ram read row A.
- o_read_matrix_a  out  1  vec_ram read-matrix select A.
- i_read_data_a  in  16 x VEC_SIZE  vec_ram read data A.
- o_write_enable  out  1  vec_ram write enable.
- o_write_index  out  VEC_INDEX_WIDTH  vec_ram write index.
- o_write_row  out  4  vec_ram write row.
- o_write_matrix  out  1  vec_ram write-matrix select.
- o_write_data  out  16 x VEC_SIZE  vec_ram write data.

Behaviour:
- Reset (i_rst=1 at posedge):
  - State goes to IDLE; row counter and latched command clear to 0.
  - All outputs are 0 except o_cmd_ready, which is 1 in IDLE.
- Reset mid-RUN aborts immediately. Rows already written stay written; no o_done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on valid&ready. The command fields are latched and the row counter is cleared to 0.
  - RUN for ZERO/FILL/COPY lasts exactly 16 cycles, rows 0..15 in ascending order. It goes to DONE after the cycle with row counter 15.
  - RUN for EXTRACT lasts exactly 1 cycle, then DONE.
  - DONE lasts 1 cycle with o_done=1, then IDLE.
- Latency: command accepted at edge T.
  - Matrix ops: writes in cycles T+1..T+16, o_done in cycle T+17, ready again in T+18.
  - EXTRACT: write in T+1, o_done in T+2, ready in T+3.
- vec_ram captures the read address on negedge and returns data combinationally, so a row is read and written in the same RUN cycle. The read address and write address are driven together from registered state. o_write_data is combinational from i_read_data_a (COPY/FILL/EXTRACT) or all-zero (ZERO).
- Per-op port drive in RUN (r = row counter):
  - ZERO: write matrix=1, index=dst, row=r, data=0. Read port A outputs are 0.
  - FILL: read matrix=0, index=src. Write matrix=1, index=dst, row=r, data=read data.
  - COPY: read matrix=1, index=src, row=r. Write matrix=1, index=dst, row=r, data=read data.
  - EXTRACT: read matrix=1, index=src, row=i_cmd_row (latched). Write matrix=0, index=dst, row=0, data=read data.
- Outside RUN: o_write_enable=0, and all address/data outputs are 0.
- COPY with src==dst is legal. It performs 16 rewrites of identical data and completes normally.
- FILL/EXTRACT into or from the same logical storage need no hazard handling; each cycle's read precedes its write edge.
- Command inputs are sampled only at acceptance. Changes while busy are ignored.
- i_cmd_valid while busy is held off (ready=0). It is not dropped and is accepted in the first IDLE cycle.
- Row counter is 4 bits. Termination is decided on counter==15, never on wrap to 0.

Decomposition:
- Shared package vec_pkg holds:
  - typedef enum logic [1:0] vec_mat_op_t {VMO_ZERO, VMO_FILL, VMO_COPY, VMO_EXTRACT}
  - constants VEC_LANES=16, MAT_ROWS=16
  - typedef enum for FSM state {VMM_IDLE, VMM_RUN, VMM_DONE}
- No sub-module: FSM, row counter and output mux stay in one module.

Test Plan:
- Reset then FILL dst=3 src=7, with vector 7 = lanes 0..15 = 16'h0001..16'h0010:
  - 16 writes, rows 0..15 of matrix 3, each with data = vector 7.
  - o_done exactly at T+17.
  - Readback of all rows of matrix 3 matches vector 7.
- COPY src=3 dst=31, where matrix 3 row r holds lane values r*16+lane:
  - Matrix 31 equals matrix 3 row-for-row.
  - Write row sequence is 0..15; o_busy is high for 17 cycles.
- EXTRACT src=31 row=9 dst=0:
  - A single write to vector 0 with matrix 31 row 9 data.
  - o_done at T+2; o_cmd_ready returns at T+3.
- ZERO dst=31 after the COPY above:
  - All 16 rows of matrix 31 read 0.
  - Matrix 3 is unchanged (no stray writes).
- Back-to-back commands with i_cmd_valid held high and fields changed mid-RUN:
  - The second command is accepted only in the IDLE cycle.
  - The first command uses only its latched fields.
- i_rst asserted when the row counter is 5 during COPY:
  - Next cycle: o_write_enable=0 and o_busy=0; no o_done.
  - Rows 0..4 of dst are written and rows 5..15 retain old data.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector/matrix datapath blocks.
package vec_pkg;

    localparam int VEC_LANES = 16;
    localparam int MAT_ROWS  = 16;

    typedef enum logic [1:0] {
        VMO_ZERO    = 2'd0,
        VMO_FILL    = 2'd1,
        VMO_COPY    = 2'd2,
        VMO_EXTRACT = 2'd3
    } vec_mat_op_t;

    typedef enum logic [1:0] {
        VMM_IDLE = 2'd0,
        VMM_RUN  = 2'd1,
        VMM_DONE = 2'd2
    } vmm_state_t;

endpackage

// File: rtl/vec_mat_mover.sv
// Bulk matrix/vector mover. Owns vec_ram read port A and the write port
// while busy. A row is read and written in the same RUN cycle because
// vec_ram returns read data combinationally.
//
// Handshake: a command is accepted on the rising edge where
// i_cmd_valid && o_cmd_ready; ready is high only in IDLE, so a valid
// held during a transfer simply waits and is taken in the first IDLE cycle.
// The FSM state is visible as the internal signal state_q.
module vec_mat_mover
    import vec_pkg::*;
#(
    parameter int VEC_SIZE        = 16,
    parameter int VEC_INDEX_WIDTH = 5
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_cmd_valid,
    output logic                                      o_cmd_ready,
    input  logic [1:0]                                i_cmd_op,
    input  logic [VEC_INDEX_WIDTH-1:0]                i_cmd_dst,
    input  logic [VEC_INDEX_WIDTH-1:0]                i_cmd_src,
    input  logic [3:0]                                i_cmd_row,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic [VEC_INDEX_WIDTH-1:0]                o_read_index_a,
    output logic [3:0]                                o_read_row_a,
    output logic                                      o_read_matrix_a,
    input  logic [VEC_LANES-1:0][VEC_SIZE-1:0]        i_read_data_a,
    output logic                                      o_write_enable,
    output logic [VEC_INDEX_WIDTH-1:0]                o_write_index,
    output logic [3:0]                                o_write_row,
    output logic                                      o_write_matrix,
    output logic [VEC_LANES-1:0][VEC_SIZE-1:0]        o_write_data
);

    localparam logic [3:0] ROW_LAST = 4'(MAT_ROWS - 1);

    vmm_state_t                 state_q;
    vmm_state_t                 state_d;
    vec_mat_op_t                op_q;
    logic [VEC_INDEX_WIDTH-1:0] dst_q;
    logic [VEC_INDEX_WIDTH-1:0] src_q;
    logic [3:0]                 xrow_q;
    logic [3:0]                 row_q;
    logic                       accept;
    logic                       last_cycle;

    assign accept     = (state_q == VMM_IDLE) && i_cmd_valid;
    // EXTRACT is a single-row move; matrix ops stop on row 15, never on wrap.
    assign last_cycle = (op_q == VMO_EXTRACT) || (row_q == ROW_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= VMM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VMM_IDLE: if (accept) state_d = VMM_RUN;
            VMM_RUN:  if (last_cycle) state_d = VMM_DONE;
            VMM_DONE: state_d = VMM_IDLE;
            default:  state_d = VMM_IDLE;
        endcase
    end

    // Command latch and row counter; fields are only sampled at acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q   <= VMO_ZERO;
            dst_q  <= '0;
            src_q  <= '0;
            xrow_q <= '0;
            row_q  <= '0;
        end else if (accept) begin
            op_q   <= vec_mat_op_t'(i_cmd_op);
            dst_q  <= i_cmd_dst;
            src_q  <= i_cmd_src;
            xrow_q <= i_cmd_row;
            row_q  <= '0;
        end else if (state_q == VMM_RUN && !last_cycle) begin
            row_q <= row_q + 4'd1;
        end
    end

    // Port drive: everything zero outside RUN, per-op addressing inside RUN.
    // Write enable is masked by reset so an abort lands no write on that edge.
    always_comb begin
        o_cmd_ready     = (state_q == VMM_IDLE);
        o_busy          = (state_q == VMM_RUN) || (state_q == VMM_DONE);
        o_done          = (state_q == VMM_DONE);
        o_read_index_a  = '0;
        o_read_row_a    = '0;
        o_read_matrix_a = 1'b0;
        o_write_enable  = 1'b0;
        o_write_index   = '0;
        o_write_row     = '0;
        o_write_matrix  = 1'b0;
        o_write_data    = '0;
        if (state_q == VMM_RUN) begin
            o_write_enable = !i_rst;
            o_write_index  = dst_q;
            case (op_q)
                VMO_ZERO: begin
                    o_write_matrix = 1'b1;
                    o_write_row    = row_q;
                end
                VMO_FILL: begin
                    o_read_index_a = src_q;
                    o_write_matrix = 1'b1;
                    o_write_row    = row_q;
                    o_write_data   = i_read_data_a;
                end
                VMO_COPY: begin
                    o_read_matrix_a = 1'b1;
                    o_read_index_a  = src_q;
                    o_read_row_a    = row_q;
                    o_write_matrix  = 1'b1;
                    o_write_row     = row_q;
                    o_write_data    = i_read_data_a;
                end
                VMO_EXTRACT: begin
                    o_read_matrix_a = 1'b1;
                    o_read_index_a  = src_q;
                    o_read_row_a    = xrow_q;
                    o_write_data    = i_read_data_a;
                end
                default: begin
                    o_write_enable = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mat_mover.sv
// Bench for vec_mat_mover with a small vec_ram model attached.
module tb_vec_mat_mover;

    localparam int VS = 16;
    localparam int IW = 5;

    typedef logic [255:0] row_t;

    logic                    i_clk;
    logic                    i_rst;
    logic                    i_cmd_valid;
    logic                    o_cmd_ready;
    logic [1:0]              i_cmd_op;
    logic [IW-1:0]           i_cmd_dst;
    logic [IW-1:0]           i_cmd_src;
    logic [3:0]              i_cmd_row;
    logic                    o_busy;
    logic                    o_done;
    logic [IW-1:0]           o_read_index_a;
    logic [3:0]              o_read_row_a;
    logic                    o_read_matrix_a;
    logic [15:0][VS-1:0]     i_read_data_a;
    logic                    o_write_enable;
    logic [IW-1:0]           o_write_index;
    logic [3:0]              o_write_row;
    logic                    o_write_matrix;
    logic [15:0][VS-1:0]     o_write_data;

    int checks   = 0;
    int failures = 0;

    // vec_ram model
    row_t vec_mem [32];
    row_t mat_mem [32][16];
    logic          pk_en  = 1'b0;
    logic          pk_mat = 1'b0;
    logic [IW-1:0] pk_idx = '0;
    logic [3:0]    pk_row = '0;
    row_t          pk_data = '0;

    // observation log, index k = cycles after the accepting edge
    logic       obs_we    [64];
    logic [3:0] obs_wrow  [64];
    logic [4:0] obs_widx  [64];
    logic       obs_wmat  [64];
    logic [3:0] obs_rrow  [64];
    logic [4:0] obs_ridx  [64];
    logic       obs_rmat  [64];
    logic       obs_done  [64];
    logic       obs_busy  [64];
    logic       obs_ready [64];

    vec_mat_mover #(.VEC_SIZE(VS), .VEC_INDEX_WIDTH(IW)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_op        (i_cmd_op),
        .i_cmd_dst       (i_cmd_dst),
        .i_cmd_src       (i_cmd_src),
        .i_cmd_row       (i_cmd_row),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_read_index_a  (o_read_index_a),
        .o_read_row_a    (o_read_row_a),
        .o_read_matrix_a (o_read_matrix_a),
        .i_read_data_a   (i_read_data_a),
        .o_write_enable  (o_write_enable),
        .o_write_index   (o_write_index),
        .o_write_row     (o_write_row),
        .o_write_matrix  (o_write_matrix),
        .o_write_data    (o_write_data)
    );

    // clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    assign i_read_data_a = o_read_matrix_a ? mat_mem[o_read_index_a][o_read_row_a]
                                           : vec_mem[o_read_index_a];

    always @(posedge i_clk) begin
        if (o_write_enable) begin
            if (o_write_matrix) mat_mem[o_write_index][o_write_row] <= o_write_data;
            else                vec_mem[o_write_index] <= o_write_data;
        end
        if (pk_en) begin
            if (pk_mat) mat_mem[pk_idx][pk_row] <= pk_data;
            else        vec_mem[pk_idx] <= pk_data;
        end
    end

    function automatic row_t mk_ramp(int base);
        row_t v;
        for (int l = 0; l < 16; l++) v[l*16 +: 16] = 16'(base + l);
        return v;
    endfunction

    function automatic row_t mk_fill(logic [15:0] val);
        row_t v;
        for (int l = 0; l < 16; l++) v[l*16 +: 16] = val;
        return v;
    endfunction

    // driver tasks
    task automatic poke(input logic mat, input logic [4:0] idx, input logic [3:0] row, input row_t data);
        @(negedge i_clk);
        pk_en = 1'b1; pk_mat = mat; pk_idx = idx; pk_row = row; pk_data = data;
        @(posedge i_clk);
        #1 pk_en = 1'b0;
    endtask

    task automatic load_mat(input logic [4:0] idx, input int base, input logic ramp);
        for (int r = 0; r < 16; r++)
            poke(1'b1, idx, 4'(r), ramp ? mk_ramp(base + r*16) : mk_fill(16'(base)));
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] dst, input logic [4:0] src, input logic [3:0] row);
        int n;
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_dst = dst; i_cmd_src = src; i_cmd_row = row;
        n = 0;
        while (!o_cmd_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (!o_cmd_ready) begin
            failures++;
            $display("FAIL send_cmd_timeout: o_cmd_ready=%b required=1", o_cmd_ready);
        end
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic record(input int k);
        obs_we[k] = o_write_enable;  obs_wrow[k] = o_write_row;   obs_widx[k] = o_write_index;
        obs_wmat[k] = o_write_matrix; obs_rrow[k] = o_read_row_a; obs_ridx[k] = o_read_index_a;
        obs_rmat[k] = o_read_matrix_a; obs_done[k] = o_done;      obs_busy[k] = o_busy;
        obs_ready[k] = o_cmd_ready;
    endtask

    task automatic observe(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge i_clk);
            record(k);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = 2'd0;
        i_cmd_dst = '0; i_cmd_src = '0; i_cmd_row = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", o_cmd_ready); end
        checks++;
        if ({o_busy, o_done, o_write_enable} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: busy/done/we=%b want 000", {o_busy, o_done, o_write_enable});
        end
        checks++;
        if ({o_write_index, o_write_row, o_write_matrix, o_read_index_a, o_read_row_a, o_read_matrix_a} !== '0
            || o_write_data !== '0) begin
            failures++; $display("FAIL reset_addr: addr/data outputs not zero wdata=%h", o_write_data);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++; $display("FAIL reset_release: ready=%b busy=%b want 1 0", o_cmd_ready, o_busy);
        end
    endtask

    task automatic test_fill;
        int dcnt;
        poke(1'b0, 5'd7, 4'd0, mk_ramp(1));
        load_mat(5'd3, 16'hDEAD, 1'b0);
        send_cmd(2'd1, 5'd3, 5'd7, 4'd0);
        observe(20);
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (!(obs_we[k] === 1'b1 && obs_wrow[k] === 4'(k-1) && obs_widx[k] === 5'd3 && obs_wmat[k] === 1'b1
                  && obs_ridx[k] === 5'd7 && obs_rmat[k] === 1'b0)) begin
                failures++;
                $display("FAIL fill_cycle%0d: we=%b row=%0d idx=%0d mat=%b ridx=%0d rmat=%b want 1 %0d 3 1 7 0",
                         k, obs_we[k], obs_wrow[k], obs_widx[k], obs_wmat[k], obs_ridx[k], obs_rmat[k], k-1);
            end
        end
        dcnt = 0;
        for (int k = 1; k <= 20; k++) if (obs_done[k] === 1'b1) dcnt++;
        checks++;
        if (obs_done[17] !== 1'b1 || dcnt != 1) begin
            failures++; $display("FAIL fill_done: done@17=%b pulses=%0d want 1 1", obs_done[17], dcnt);
        end
        checks++;
        if (obs_we[17] !== 1'b0 || obs_ready[17] !== 1'b0 || obs_ready[18] !== 1'b1) begin
            failures++; $display("FAIL fill_tail: we@17=%b ready@17=%b ready@18=%b want 0 0 1",
                                 obs_we[17], obs_ready[17], obs_ready[18]);
        end
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (mat_mem[3][r] !== mk_ramp(1)) begin
                failures++; $display("FAIL fill_row%0d: got %h want %h", r, mat_mem[3][r], mk_ramp(1));
            end
        end
    endtask

    task automatic test_copy;
        int bcnt;
        load_mat(5'd3, 0, 1'b1);
        load_mat(5'd31, 16'hBEEF, 1'b0);
        send_cmd(2'd2, 5'd31, 5'd3, 4'd0);
        observe(20);
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (!(obs_we[k] === 1'b1 && obs_wrow[k] === 4'(k-1) && obs_rrow[k] === 4'(k-1) && obs_widx[k] === 5'd31
                  && obs_ridx[k] === 5'd3 && obs_rmat[k] === 1'b1 && obs_wmat[k] === 1'b1)) begin
                failures++;
                $display("FAIL copy_cycle%0d: we=%b wrow=%0d rrow=%0d widx=%0d ridx=%0d want row %0d",
                         k, obs_we[k], obs_wrow[k], obs_rrow[k], obs_widx[k], obs_ridx[k], k-1);
            end
        end
        bcnt = 0;
        for (int k = 1; k <= 20; k++) if (obs_busy[k] === 1'b1) bcnt++;
        checks++;
        if (bcnt != 17) begin failures++; $display("FAIL copy_busy_len: got %0d want 17", bcnt); end
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (mat_mem[31][r] !== mk_ramp(r*16)) begin
                failures++; $display("FAIL copy_row%0d: got %h want %h", r, mat_mem[31][r], mk_ramp(r*16));
            end
        end
    endtask

    task automatic test_extract;
        poke(1'b0, 5'd0, 4'd0, mk_fill(16'h5A5A));
        send_cmd(2'd3, 5'd0, 5'd31, 4'd9);
        observe(5);
        checks++;
        if (!(obs_we[1] === 1'b1 && obs_wmat[1] === 1'b0 && obs_widx[1] === 5'd0 && obs_wrow[1] === 4'd0
              && obs_rmat[1] === 1'b1 && obs_ridx[1] === 5'd31 && obs_rrow[1] === 4'd9)) begin
            failures++;
            $display("FAIL extract_addr: we=%b wmat=%b widx=%0d wrow=%0d rmat=%b ridx=%0d rrow=%0d want 1 0 0 0 1 31 9",
                     obs_we[1], obs_wmat[1], obs_widx[1], obs_wrow[1], obs_rmat[1], obs_ridx[1], obs_rrow[1]);
        end
        checks++;
        if (obs_we[2] !== 1'b0 || obs_done[2] !== 1'b1 || obs_done[1] !== 1'b0) begin
            failures++; $display("FAIL extract_done: we@2=%b done@1=%b done@2=%b want 0 0 1",
                                 obs_we[2], obs_done[1], obs_done[2]);
        end
        checks++;
        if (obs_ready[2] !== 1'b0 || obs_ready[3] !== 1'b1) begin
            failures++; $display("FAIL extract_ready: ready@2=%b ready@3=%b want 0 1", obs_ready[2], obs_ready[3]);
        end
        checks++;
        if (vec_mem[0] !== mk_ramp(144)) begin
            failures++; $display("FAIL extract_data: got %h want %h", vec_mem[0], mk_ramp(144));
        end
    endtask

    task automatic test_zero;
        int bad;
        send_cmd(2'd0, 5'd31, 5'd4, 4'd0);
        observe(20);
        bad = 0;
        for (int k = 1; k <= 16; k++)
            if (!(obs_we[k] === 1'b1 && obs_wrow[k] === 4'(k-1) && obs_widx[k] === 5'd31 && obs_wmat[k] === 1'b1
                  && obs_rmat[k] === 1'b0 && obs_ridx[k] === 5'd0 && obs_rrow[k] === 4'd0)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL zero_ports: bad cycles=%0d want 0", bad); end
        checks++;
        if (obs_done[17] !== 1'b1) begin failures++; $display("FAIL zero_done: done@17=%b want 1", obs_done[17]); end
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (mat_mem[31][r] !== '0 || mat_mem[3][r] !== mk_ramp(r*16)) begin
                failures++; $display("FAIL zero_row%0d: m31=%h m3=%h want 0 and %h",
                                     r, mat_mem[31][r], mat_mem[3][r], mk_ramp(r*16));
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc_k;
        int bad;
        int rdy_bad;
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_op = 2'd1; i_cmd_dst = 5'd5; i_cmd_src = 5'd7; i_cmd_row = 4'd0;
        @(posedge i_clk);
        acc_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge i_clk);
            if (k == 1) begin
                i_cmd_op = 2'd2; i_cmd_dst = 5'd6; i_cmd_src = 5'd3; i_cmd_row = 4'd4;
            end
            record(k);
            if (acc_k != 0 && k == acc_k + 1) i_cmd_valid = 1'b0;
            if (o_cmd_ready && acc_k == 0) acc_k = k;
        end
        i_cmd_valid = 1'b0;
        checks++;
        if (acc_k != 18) begin failures++; $display("FAIL b2b_accept: accepted at %0d want 18", acc_k); end
        rdy_bad = 0;
        for (int k = 1; k <= 17; k++) if (obs_ready[k] !== 1'b0) rdy_bad++;
        checks++;
        if (rdy_bad != 0) begin failures++; $display("FAIL b2b_held_off: ready high in %0d busy cycles want 0", rdy_bad); end
        bad = 0;
        for (int k = 1; k <= 16; k++)
            if (!(obs_we[k] === 1'b1 && obs_widx[k] === 5'd5 && obs_ridx[k] === 5'd7 && obs_rmat[k] === 1'b0)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL b2b_first_latched: bad cycles=%0d want 0", bad); end
        bad = 0;
        for (int k = 19; k <= 34; k++)
            if (!(obs_we[k] === 1'b1 && obs_widx[k] === 5'd6 && obs_wrow[k] === 4'(k-19) && obs_ridx[k] === 5'd3)) bad++;
        checks++;
        if (bad != 0 || obs_done[35] !== 1'b1) begin
            failures++; $display("FAIL b2b_second: bad cycles=%0d done@35=%b want 0 1", bad, obs_done[35]);
        end
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (mat_mem[5][r] !== mk_ramp(1) || mat_mem[6][r] !== mk_ramp(r*16)) begin
                failures++; $display("FAIL b2b_row%0d: m5=%h m6=%h want %h %h",
                                     r, mat_mem[5][r], mat_mem[6][r], mk_ramp(1), mk_ramp(r*16));
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int dcnt;
        load_mat(5'd10, 16'hAAAA, 1'b0);
        send_cmd(2'd2, 5'd10, 5'd3, 4'd0);
        repeat (6) @(negedge i_clk);
        checks++;
        if (o_write_row !== 4'd5 || o_write_enable !== 1'b1) begin
            failures++; $display("FAIL abort_pre: row=%0d we=%b want 5 1", o_write_row, o_write_enable);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++;
        if ({o_write_enable, o_busy, o_done} !== 3'b000 || o_cmd_ready !== 1'b1) begin
            failures++; $display("FAIL abort_post: we/busy/done=%b ready=%b want 000 1",
                                 {o_write_enable, o_busy, o_done}, o_cmd_ready);
        end
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL abort_no_done: pulses=%0d want 0", dcnt); end
        for (int r = 0; r < 16; r++) begin
            checks++;
            if (mat_mem[10][r] !== ((r < 5) ? mk_ramp(r*16) : mk_fill(16'hAAAA))) begin
                failures++; $display("FAIL abort_row%0d: got %h", r, mat_mem[10][r]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_copy;
        test_extract;
        test_zero;
        test_back_to_back;
        test_reset_mid_run;
        repeat (2) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
